booth_radix4_seq_mult: RTL and testbench

BOOTH_RADIX4_SEQ_MULT -- requirements
Module: booth_radix4_seq_mult

---
 rtl/booth_radix4_seq_mult.sv | 125 ++++++++++++
 tb/tb_booth_radix4_seq_mult.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, signed N x N -> 2N.
// Define BOOTH_ZERO_SKIP_EN to finish early once the remaining multiplier bits are all sign.
module booth_radix4_seq_mult #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int G  = N / 2;
    localparam int CW = $clog2(G + 1);
    localparam logic [CW-1:0] LAST = CW'(G - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N:0]       b_q, b_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [2*N-1:0]   a_ext;
    logic [2*N-1:0]   pp;
    logic [2*N-1:0]   pp_sh;
    logic [2:0]       grp;
    logic             skip;

    // b_q holds {B, b[-1]}, so bit 2*cnt is the low bit of the current group
    always_comb begin
        a_ext = {{N{a_q[N-1]}}, a_q};
        grp   = 3'(b_q >> {cnt_q, 1'b0});
        case (grp)
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            default:        pp = -a_ext;
        endcase
        pp_sh = pp << {cnt_q, 1'b0};
    end

`ifdef BOOTH_ZERO_SKIP_EN
    logic [N:0] hi;

    // arithmetic shift leaves only b[N-1:2cnt-1]; all-0 or all-1 adds nothing more
    always_comb begin
        hi   = $signed(b_q) >>> {cnt_q, 1'b0};
        skip = (hi == '0) || (&hi);
    end
`else
    always_comb begin
        skip = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = multiplicand;
                    b_d     = {multiplier, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (skip) begin
                    state_d = DONE;
                end else begin
                    acc_d = acc_q + pp_sh;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Directed and random checks of booth_radix4_seq_mult at N=8 and N=24.
module tb_booth_radix4_seq_mult;

    logic        clk;
    logic        rst;

    logic        v8, ir8, ov8, r8, bz8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        v24, ir24, ov24, r24, bz24;
    logic [23:0] a24, b24;
    logic [47:0] p24;

    int errors;
    int checks;

    booth_radix4_seq_mult #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(v8), .in_ready(ir8),
        .multiplicand(a8), .multiplier(b8),
        .out_valid(ov8), .out_ready(r8),
        .product(p8), .busy(bz8)
    );

    booth_radix4_seq_mult #(.N(24)) dut24 (
        .clk(clk), .rst(rst),
        .in_valid(v24), .in_ready(ir24),
        .multiplicand(a24), .multiplier(b24),
        .out_valid(ov24), .out_ready(r24),
        .product(p24), .busy(bz24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // edges from acceptance to out_valid for N=8
    function automatic int exp_lat8(input logic [7:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
        logic [8:0] e;
        logic ones, zeros;
        e = {b, 1'b0};
        for (int c = 0; c < 4; c++) begin
            ones  = 1'b1;
            zeros = 1'b1;
            for (int i = 2 * c; i <= 8; i++) begin
                ones  = ones & e[i];
                zeros = zeros & ~e[i];
            end
            if (ones || zeros) return c + 1;
        end
        return 4;
`else
        return 4;
`endif
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string tag);
        int lat;
        lat = 0;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(ir8), 64'd1);
        v8 = 1'b1;
        a8 = a;
        b8 = b;
        @(negedge clk);
        v8 = 1'b0;
        a8 = 8'h5A;
        b8 = 8'hA5;
        chk({tag, "_busy"}, 64'(bz8), 64'd1);
        chk({tag, "_run_prod"}, 64'(p8), 64'd0);
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat8(b)));
        chk({tag, "_prod"}, 64'(p8), 64'(exp));
        @(negedge clk);
        chk({tag, "_ov_clr"}, 64'(ov8), 64'd0);
        chk({tag, "_ready_back"}, 64'(ir8), 64'd1);
    endtask

    initial begin
        logic [15:0] hold;
        logic [47:0] e24;
        longint      pr;
        int          n;
        int          seen;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; r8 = 1'b1;
        v24 = 1'b0; a24 = '0; b24 = '0; r24 = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_ov", 64'(ov8), 64'd0);
        chk("rst_busy", 64'(bz8), 64'd0);
        chk("rst_prod", 64'(p8), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 64'(ir8), 64'd1);
        chk("rel_ready24", 64'(ir24), 64'd1);

        op8(8'd3, 8'd5, 16'h000F, "basic");
        op8(8'h80, 8'h80, 16'h4000, "minmin");
        op8(8'd127, 8'hFF, 16'hFF81, "max_m1");
        op8(8'h80, 8'd127, 16'hC080, "min_max");
        op8(8'hFF, 8'hFF, 16'h0001, "m1m1");
        op8(8'd100, 8'hFD, 16'hFED4, "100_m3");
        op8(8'd77, 8'h00, 16'h0000, "b_zero");
        op8(8'd9, 8'd1, 16'h0009, "nine_one");
        op8(8'd9, 8'hFF, 16'hFFF7, "nine_m1");
        op8(8'd3, 8'h55, 16'h00FF, "b55");

        // backpressure: hold out_ready low in DONE
        r8 = 1'b0;
        @(negedge clk);
        v8 = 1'b1; a8 = 8'hF9; b8 = 8'd6;
        @(negedge clk);
        v8 = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_prod", 64'(p8), 64'hFFD6);
        hold = p8;
        for (int i = 0; i < 3; i++) begin
            v8 = (i == 1);
            a8 = 8'd2; b8 = 8'd2;
            @(negedge clk);
            chk("bp_ov", 64'(ov8), 64'd1);
            chk("bp_hold", 64'(p8), 64'(hold));
            chk("bp_ready", 64'(ir8), 64'd0);
        end
        v8 = 1'b0;
        r8 = 1'b1;
        @(negedge clk);
        chk("bp_release_ov", 64'(ov8), 64'd0);
        chk("bp_release_ready", 64'(ir8), 64'd1);
        chk("bp_pulse_ignored", 64'(bz8), 64'd0);

        // reset on the second RUN edge aborts the operation
        v8 = 1'b1; a8 = 8'd5; b8 = 8'd7;
        @(negedge clk);
        v8 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ov", 64'(ov8), 64'd0);
        chk("abort_prod", 64'(p8), 64'd0);
        chk("abort_ready", 64'(ir8), 64'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov8) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);

        // reset and in_valid together: reset wins
        rst = 1'b1; v8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
        @(negedge clk);
        rst = 1'b0; v8 = 1'b0;
        chk("rst_vs_valid", 64'(bz8), 64'd0);
        @(negedge clk);
        chk("rst_vs_valid2", 64'(bz8), 64'd0);

        // N=24: extreme pair first, then random pairs with random out_ready
        for (int k = 0; k < 1000; k++) begin
            if (k == 0) begin
                a24 = 24'h800000; b24 = 24'h800000;
            end else begin
                a24 = 24'($urandom);
                b24 = 24'($urandom);
            end
            pr  = longint'($signed(a24)) * longint'($signed(b24));
            e24 = pr[47:0];
            if (k == 0) chk("n24_minmin_ref", 64'(e24), 64'h4000_0000_0000);
            v24 = 1'b1;
            n = 0;
            @(negedge clk);
            v24 = 1'b0;
            a24 = 24'($urandom);
            b24 = 24'($urandom);
            while (!ov24 && n < 60) begin
                r24 = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            chk("n24_prod", 64'(p24), 64'(e24));
            n = 0;
            r24 = 1'($urandom_range(0, 1));
            while (!r24 && n < 20) begin
                @(negedge clk);
                n++;
                r24 = 1'($urandom_range(0, 1));
            end
            r24 = 1'b1;
            @(negedge clk);
            r24 = 1'b0;
            if (ir24 !== 1'b1) chk("n24_ready", 64'(ir24), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
